mmio_uart_tx: RTL and testbench
===============================

# mmio_uart_tx

Memory-mapped UART transmitter sitting on the CPU data bus beside the data memory, in the MMIO window at 0xFFFF0008 (MARS-compatible transmitter control/data pair). The CPU's store path writes bytes into an internal FIFO. A baud-rate FSM serialises them as 8N1 frames on `txd`. The read path returns status through the same combinational read mux that serves the data memory.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000: clock frequency.
- `BAUD`, 115200: line rate. `DIV = CLK_HZ/BAUD`, truncated, must be ≥ 2.
- `FIFO_DEPTH`, 8: power of two, 2..16.
- `BASE`, 32'hFFFF0008: word address of the control register. Data register is at `BASE+4`.

Ports:
- `clock  in  1`: CPU clock.
- `reset  in  1`: asynchronous, active-high.
- `addr  in  32`: data-bus byte address.
- `wdata  in  32`: store data.
- `we  in  1`: store strobe from the CPU.
- `sel  out  1`: combinational. `addr[31:3]==BASE[31:3]`. Gates the data-memory write enable and steers the read mux.
- `rdata  out  32`: combinational register read, valid when `sel`.
- `txd  out  1`: serial line, idle high.
- `irq  out  1`: transmit-empty interrupt.

## Operation
- Register decode uses word accesses only. `addr[2]=0` selects control, `addr[2]=1` selects data. `addr[1:0]` is ignored.
- Control read:
  - bit0 `ready` = FIFO not full.
  - bit1 `ie`.
  - bit2 `ovf` (sticky).
  - bit3 `busy` = FSM not IDLE or FIFO not empty.
  - bits[11:8] = FIFO count.
  - All other bits 0.
- Data read returns 0.
- Control write (`sel & we & ~addr[2]`): `ie <= wdata[1]`. If `wdata[2]=1`, `ovf` is cleared.
- Data write (`sel & we & addr[2]`):
  - If not full, `wdata[7:0]` is pushed.
  - If full, the byte is dropped and `ovf` is set.
  - A simultaneous pop in the same cycle frees a slot, so the push is accepted and the count is unchanged.
- FSM states and transitions:
  - IDLE: `txd=1`. If FIFO not empty, pop into the shift register and go to START.
  - START: `txd=0` for DIV cycles, then go to DATA with bit index 0.
  - DATA: `txd=shift[0]` for DIV cycles per bit, LSB first. After bit 7, go to STOP.
  - STOP: `txd=1` for DIV cycles. If FIFO not empty, pop and go straight to START (no idle gap). Otherwise go to IDLE.
- Baud counter:
  - Counts 0..DIV-1; the bit advances when the count reaches DIV-1.
  - Reloads to 0 on every state change.
  - Width is `$clog2(DIV)`.
- Reset, including mid-frame:
  - Outputs: `txd=1`, `irq=0`; FSM returns to IDLE.
  - FIFO is emptied (count 0), with pointers and `ie`, `ovf` cleared.
  - A partial frame is abandoned. No stop bit is emitted.

## Timing
- Register writes take effect at the rising `clock` edge where `sel & we` holds.
- Reads are purely combinational from current state.
- A data write at edge N into an idle, empty block:
  - count=1 after edge N.
  - Pop at edge N+1; `txd` falls after edge N+1.
  - The frame lasts exactly 10·DIV cycles, then `busy` drops.
- Back-to-back frames are continuous: the stop bit of one is followed immediately by the start bit of the next.
- Pointers wrap modulo FIFO_DEPTH. Count runs from 0 to FIFO_DEPTH inclusive.

## Configuration
- With `UART_TX_IRQ_EN` defined:
  - `irq` is registered. It is set to `ie & ~busy` each cycle, so it asserts one cycle after the block goes idle with `ie=1`.
- Without the macro:
  - `irq` is tied to 0.
  - The `ie` bit is not stored and reads 0.
  - Control writes affect only `ovf`.

## Structure
- Package `uart_pkg` holds:
  - the FSM state enum (IDLE, START, DATA, STOP);
  - register offsets (CTRL_OFS=0, DATA_OFS=4);
  - control bit positions (READY, IE, OVF, BUSY, COUNT_LSB=8).
- Sub-module `tx_fifo`: synchronous FIFO, byte-wide, depth-parameterised, with push/pop/full/empty/count outputs and the same asynchronous reset.
- FSM, decode and baud counter live in the top module.

## Test plan
Bench parameters: CLK_HZ=1000, BAUD=100, so DIV=10.
- Write 0xA5 to the data register while idle → `txd` falls 2 edges later. Sampling mid-bit gives 0, then 1,0,1,0,0,1,0,1, then 1. `busy` clears after 100 cycles.
- Write 3 bytes back-to-back → 300 contiguous cycles of framing with no idle-high gaps between stop and start bits.
- Write 9 bytes in consecutive cycles (DEPTH=8):
  - The first pops immediately, so all 9 are accepted; a 10th write sets `ovf`.
  - Control then reads ready=0, ovf=1.
  - Writing 0x4 to control clears `ovf`.
- Assert `reset` mid-DATA (cycle 35 of a frame) with 4 bytes queued → `txd=1` immediately, count=0, and no further transitions after release.
- With `UART_TX_IRQ_EN`: set `ie`, send one byte → `irq` is 0 during the frame and rises 1 cycle after `busy` falls. Without the macro, `irq` stays 0 and control bit1 reads 0.
- Decode:
  - `addr` = 0xFFFF0010 → `sel=0`, no state change on `we`.
  - `addr` = 0xFFFF000E → treated as data register.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and register layout for the MMIO UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

  localparam logic [2:0] CTRL_OFS = 3'd0;
  localparam logic [2:0] DATA_OFS = 3'd4;

  localparam int unsigned READY     = 0;
  localparam int unsigned IE        = 1;
  localparam int unsigned OVF       = 2;
  localparam int unsigned BUSY      = 3;
  localparam int unsigned COUNT_LSB = 8;

endpackage

// File: rtl/tx_fifo.sv
// Byte-wide synchronous FIFO; a push while full is accepted only if a pop frees a slot.
module tx_fifo #(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [7:0]    wdata_i,
  input  logic          pop_i,
  output logic [7:0]    rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

  always_comb begin
    wptr_d  = do_push ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = do_pop ? rptr_q + PW'(1) : rptr_q;
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// MARS-style MMIO UART transmitter: control/data register pair, byte FIFO, 8N1 serialiser.
// Define UART_TX_IRQ_EN to store the ie bit and drive a registered transmit-empty irq.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] BASE       = 32'hFFFF0008
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic        sel,
  output logic [31:0] rdata,
  output logic        txd,
  output logic        irq
);

  localparam int unsigned DIV = CLK_HZ / BAUD;
  localparam int unsigned BW  = $clog2(DIV);
  localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;

  tx_state_e     state_q, state_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          ovf_q, ovf_d;

  logic          wr_ctrl, wr_data, pop, full, empty, busy, ie, baud_end;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] count;
  logic          unused_bits;

  assign sel     = (addr[31:3] == BASE[31:3]);
  assign wr_ctrl = sel & we & (addr[2] == CTRL_OFS[2]);
  assign wr_data = sel & we & (addr[2] == DATA_OFS[2]);
  assign busy    = (state_q != StIdle) | ~empty;
  assign txd     = txd_q;
  assign unused_bits = ^{wdata[31:8], wdata[3], wdata[1:0], addr[1:0]};

  tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clock),
    .rst_i  (reset),
    .push_i (wr_data),
    .wdata_i(wdata[7:0]),
    .pop_i  (pop),
    .rdata_o(fifo_rdata),
    .full_o (full),
    .empty_o(empty),
    .count_o(count)
  );

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    txd_d    = txd_q;
    pop      = 1'b0;
    baud_end = (cnt_q == BW'(DIV - 1));
    cnt_d    = baud_end ? '0 : cnt_q + BW'(1);
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        txd_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          txd_d   = 1'b0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (baud_end) begin
          bit_d   = 3'd0;
          txd_d   = shift_q[0];
          state_d = StData;
        end
      end
      StData: begin
        if (baud_end) begin
          if (bit_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = StStop;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
          end
        end
      end
      StStop: begin
        if (baud_end) begin
          // Chain straight into the next start bit when more data is queued.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = fifo_rdata;
            txd_d   = 1'b0;
            state_d = StStart;
          end else begin
            txd_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (wr_ctrl && wdata[OVF]) begin
      ovf_d = 1'b0;
    end
    if (wr_data && full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef UART_TX_IRQ_EN
  logic ie_q, ie_d, irq_q, irq_d;

  always_comb begin
    ie_d  = wr_ctrl ? wdata[IE] : ie_q;
    irq_d = ie_q & ~busy;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ie_q  <= ie_d;
      irq_q <= irq_d;
    end
  end

  assign ie  = ie_q;
  assign irq = irq_q;
`else
  assign ie  = 1'b0;
  assign irq = 1'b0;
`endif

  // Count field is 4 bits wide; a full 16-deep FIFO is told apart by ready=0.
  always_comb begin
    rdata = '0;
    if (addr[2] == CTRL_OFS[2]) begin
      rdata[READY]              = ~full;
      rdata[IE]                 = ie;
      rdata[OVF]                = ovf_q;
      rdata[BUSY]               = busy;
      rdata[COUNT_LSB +: 4]     = 4'(count);
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: line waveform predicted from 8N1 frame arithmetic.
module tb_mmio_uart_tx;

  localparam int DIV = 10;
  localparam logic [31:0] BASE = 32'hFFFF0008;
  localparam logic [31:0] DREG = 32'hFFFF000C;

  logic        clock, reset, we, sel, txd, irq;
  logic [31:0] addr, wdata, rdata;
  int          cyc = 0;
  int          n_assert = 0;
  int          n_fail = 0;
  logic        exp_ie;
  logic [7:0]  exp_q[$];

  mmio_uart_tx #(
    .CLK_HZ    (1000),
    .BAUD      (100),
    .FIFO_DEPTH(8),
    .BASE      (BASE)
  ) dut (
    .clock(clock),
    .reset(reset),
    .addr (addr),
    .wdata(wdata),
    .we   (we),
    .sel  (sel),
    .rdata(rdata),
    .txd  (txd),
    .irq  (irq)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    tick();
    we   = 1'b0;
    addr = BASE;
    #1;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v    = rdata;
    addr = BASE;
    #1;
  endtask

  // Bit idx of an 8N1 frame: 0 start, 1..8 data LSB first, 9 stop.
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return b[idx-1];
  endfunction

  // Line is checked every cycle until all queued frames of exp_q, starting at edge `start`, end.
  task automatic run_stream(input int start);
    int total;
    logic [31:0] v;
    total = exp_q.size() * 10 * DIV;
    while (cyc < start + total) begin
      logic e;
      if (cyc < start) e = 1'b1;
      else e = frame_bit(exp_q[(cyc - start) / (10 * DIV)], ((cyc - start) / DIV) % 10);
      check("txd", 32'(txd), 32'(e));
      check("busy", 32'(rdata[3]), 32'd1);
`ifdef UART_TX_IRQ_EN
      if (cyc >= start) check("irq_frame", 32'(irq), 32'd0);
`endif
      tick();
    end
    check("txd_idle", 32'(txd), 32'd1);
    rd(BASE, v);
    check("ctrl_idle", v, {30'd0, exp_ie, 1'b1});
    check("irq_at_idle", 32'(irq), 32'd0);
    tick();
    check("irq_after_idle", 32'(irq), 32'(exp_ie));
  endtask

  initial begin
    logic [31:0] v;
    logic [7:0]  b, b0;
    int          start, low_cnt;

    reset  = 1'b0;
    we     = 1'b0;
    addr   = BASE;
    wdata  = '0;
    exp_ie = 1'b0;
    #1 reset = 1'b1;
    repeat (3) tick();
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_sel", 32'(sel), 32'd1);
    rd(BASE, v);
    check("rst_ctrl", v, 32'h1);
    reset = 1'b0;
    tick();

    // Single 0xA5 frame.
    exp_q = {8'hA5};
    bus_write(DREG, 32'hA5);
    start = cyc + 1;
    rd(BASE, v);
    check("ctrl_after_push", v, 32'h109);
    run_stream(start);

    // Single random frame.
    b = 8'($urandom);
    exp_q = {b};
    bus_write(DREG, {24'($urandom), b});
    start = cyc + 1;
    run_stream(start);

    // Three back-to-back frames.
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      bus_write(DREG, {24'($urandom), b});
      if (i == 0) start = cyc + 1;
    end
    run_stream(start);

    // Ten writes into an 8-deep FIFO: nine fit, the tenth overflows.
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      if (i < 9) exp_q.push_back(b);
      bus_write(DREG, {24'd0, b});
      if (i == 0) start = cyc + 1;
    end
    rd(BASE, v);
    check("ovf_ctrl", v, 32'h80C);
    bus_write(BASE, 32'h4);
    rd(BASE, v);
    check("ovf_clear", v, 32'h808);
    run_stream(start);

    // Decode: out-of-window write is ignored; addr[1:0] is don't-care.
    addr  = 32'hFFFF0010;
    wdata = 32'h0000_00A6;
    we    = 1'b1;
    #1;
    check("sel_outside", 32'(sel), 32'd0);
    tick();
    we   = 1'b0;
    addr = BASE;
    #1;
    rd(BASE, v);
    check("outside_no_effect", v, 32'h1);
    rd(32'hFFFF0009, v);
    check("ctrl_alias", v, 32'h1);
    addr = 32'hFFFF000E;
    #1;
    check("sel_data_alias", 32'(sel), 32'd1);
    check("data_read_zero", rdata, 32'd0);
    addr = BASE;
    b = 8'($urandom);
    exp_q = {b};
    bus_write(32'hFFFF000E, {24'd0, b});
    start = cyc + 1;
    run_stream(start);

    // Interrupt enable and transmit-empty irq.
    bus_write(BASE, 32'h2);
`ifdef UART_TX_IRQ_EN
    exp_ie = 1'b1;
`else
    exp_ie = 1'b0;
`endif
    rd(BASE, v);
    check("ie_readback", v, {30'd0, exp_ie, 1'b1});
    check("irq_lags_ie", 32'(irq), 32'd0);
    tick();
    check("irq_idle", 32'(irq), 32'(exp_ie));
    b = 8'($urandom);
    exp_q = {b};
    bus_write(DREG, {24'd0, b});
    start = cyc + 1;
    run_stream(start);

    // Reset mid-DATA with four bytes still queued.
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      if (i == 0) b0 = b;
      bus_write(DREG, {24'd0, b});
      if (i == 0) start = cyc + 1;
    end
    while (cyc < start + 35) tick();
    check("pre_reset_txd", 32'(txd), 32'(frame_bit(b0, 3)));
    reset = 1'b1;
    #1;
    exp_ie = 1'b0;
    check("reset_txd", 32'(txd), 32'd1);
    check("reset_irq", 32'(irq), 32'd0);
    rd(BASE, v);
    check("reset_ctrl", v, 32'h1);
    repeat (2) tick();
    reset = 1'b0;
    low_cnt = 0;
    repeat (200) begin
      tick();
      if (txd !== 1'b1) low_cnt++;
    end
    check("no_tx_after_reset", 32'(low_cnt), 32'd0);
    rd(BASE, v);
    check("post_reset_ctrl", v, 32'h1);
    check("post_reset_irq", 32'(irq), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
